// File: rtl/chunked_adder_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock with a registered ripple carry.
// Latency: out_valid rises NCHUNK edges after the accepting edge; one operation per NCHUNK+2 cycles at best.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only while IDLE.
module chunked_adder_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             cmsb;
  logic             last;
  logic [WIDTH-1:0] work_nxt;
  int               base;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One chunk of the ripple: slice the operands, add with the registered carry, splice into the working sum.
  always_comb begin
    base     = int'(idx) * CHUNK;
    ca       = opa[base +: CHUNK];
    cb       = opb[base +: CHUNK];
    {cc, cs} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
    // Carry into the top bit of this chunk; only meaningful on the last chunk (carry into the MSB).
    cmsb     = cs[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
    last     = (idx == IW'(NCHUNK - 1));
    work_nxt = work;
    work_nxt[base +: CHUNK] = cs;
  end

  // Control FSM plus datapath registers; outputs only update on entry to DONE so partial sums never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            // Subtraction is A + ~B + 1: invert B here and force the initial carry.
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            work  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= cc;
          idx   <= idx + IW'(1);
          if (last) begin
            sum   <= work_nxt;
            cout  <= cc;
            ovf   <= cmsb ^ cc;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder_seq.sv
module tb_chunked_adder_seq;

  localparam int NCH [3] = '{4, 1, 8};
  localparam int WID [3] = '{16, 3, 8};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  iv, ordy, cinv, subv;
  wire  [2:0]  ir, ov, co, of;
  logic [15:0] a16, b16;
  logic [2:0]  a3, b3;
  logic [7:0]  a8, b8;
  wire  [15:0] s16;
  wire  [2:0]  s3;
  wire  [7:0]  s8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  chunked_adder_seq #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a16), .b(b16),
    .cin(cinv[0]), .sub(subv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(s16), .cout(co[0]), .ovf(of[0]));

  chunked_adder_seq #(.WIDTH(3), .CHUNK(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a3), .b(b3),
    .cin(cinv[1]), .sub(subv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s3), .cout(co[1]), .ovf(of[1]));

  chunked_adder_seq #(.WIDTH(8), .CHUNK(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a8), .b(b8),
    .cin(cinv[2]), .sub(subv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(s8), .cout(co[2]), .ovf(of[2]));

  // Reference: plain modular arithmetic over w bits. Returns {ovf, cout, sum[15:0]}.
  function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
    logic [16:0] m17, full;
    logic [15:0] mask, aa, bb, s;
    logic        c, v;
    m17  = (17'h1 << w) - 17'h1;
    mask = m17[15:0];
    aa   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {16'h0, (sub ? 1'b1 : cin)};
    s    = full[15:0] & mask;
    c    = full[w];
    v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {v, c, s};
  endfunction

  function automatic logic [15:0] get_sum(int k);
    case (k)
      0:       return s16;
      1:       return {13'h0, s3};
      default: return {8'h0, s8};
    endcase
  endfunction

  task automatic set_ops(int k, logic [15:0] a, logic [15:0] b, logic c, logic s);
    case (k)
      0:       begin a16 = a;      b16 = b;      end
      1:       begin a3  = a[2:0]; b3  = b[2:0]; end
      default: begin a8  = a[7:0]; b8  = b[7:0]; end
    endcase
    cinv[k] = c;
    subv[k] = s;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation on instance k, check latency and result; optionally retire it.
  task automatic run_op(int k, logic [15:0] a, logic [15:0] b, logic cin, logic sub, bit retire);
    int n;
    int lat;
    logic [17:0] e;
    n = 0;
    while (ir[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_idle", 32'(ir[k]), 32'd1);
    set_ops(k, a, b, cin, sub);
    iv[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0;
    // Changing operands after acceptance must not affect the result.
    set_ops(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    chk("in_ready_busy", 32'(ir[k]), 32'd0);
    lat = 0;
    while (ov[k] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(NCH[k]));
    e = model(WID[k], a, b, cin, sub);
    chk("sum",  32'(get_sum(k)), 32'(e[15:0]));
    chk("cout", 32'(co[k]), 32'(e[16]));
    chk("ovf",  32'(of[k]), 32'(e[17]));
    if (retire) begin
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      chk("retired", 32'(ov[k]), 32'd0);
      chk("held_sum", 32'(get_sum(k)), 32'(e[15:0]));
    end
  endtask

  initial begin
    logic [17:0] e;
    rst = 1'b1;
    iv = '0; ordy = '0; cinv = '0; subv = '0;
    a16 = '0; b16 = '0; a3 = '0; b3 = '0; a8 = '0; b8 = '0;
    #1;
    chk("rst_out_valid", 32'(ov), 32'd0);
    chk("rst_in_ready",  32'(ir), 32'h7);
    chk("rst_sum16", 32'(s16), 32'd0);
    chk("rst_cout",  32'(co), 32'd0);
    chk("rst_ovf",   32'(of), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, 16/4.
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    run_op(0, 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b1);
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);

    // Backpressure: hold the result for 6 cycles while the input side churns.
    run_op(0, 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b0);
    e = model(16, 16'h1234, 16'h0FED, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      iv[0] = i[0];
      set_ops(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      chk("bp_out_valid", 32'(ov[0]), 32'd1);
      chk("bp_sum",  32'(s16), 32'(e[15:0]));
      chk("bp_cout", 32'(co[0]), 32'(e[16]));
      chk("bp_ovf",  32'(of[0]), 32'(e[17]));
      chk("bp_in_ready", 32'(ir[0]), 32'd0);
    end
    // Retire with in_valid also high: operands must not be taken on that edge.
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    chk("bp_retire_idle", 32'(ir[0]), 32'd1);
    chk("bp_retire_valid", 32'(ov[0]), 32'd0);
    @(negedge clk);
    chk("bp_not_accepted", 32'(ir[0]), 32'd1);

    // Asynchronous reset two cycles into RUN.
    set_ops(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_sum", 32'(s16), 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_result", 32'(ov[0]), 32'd0);
    end

    // Corner configurations.
    run_op(1, 16'd7, 16'd7, 1'b1, 1'b0, 1'b1);
    run_op(2, 16'h00AA, 16'h0055, 1'b1, 1'b0, 1'b1);

    // Randomized operations on all three configurations.
    for (int i = 0; i < 25; i++)
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 12; i++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 12; i++)
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/chunked_adder_seq.md
Name: chunked_adder_seq

Overview:
Parametrised multi-cycle adder/subtractor, successor to the fixed 3-bit combinational adders. Computes A+B+Cin or A−B over WIDTH bits, CHUNK bits per clock, rippling the carry through a register between chunks. Trades latency for a short carry chain. Valid/ready handshake on input and output so it drops into datapath pipelines.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of CHUNK.
CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in; ignored when sub=1.
sub  input  1  0: A+B+cin; 1: A+~B+1 (A−B).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
cout  output  1  carry out of MSB (sub: 1 = no borrow).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, in-flight operation discarded. Outputs: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. Chunk index, carry and operand registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1 at a clock edge, capture a and b (b inverted if sub=1), set carry = sub ? 1 : cin, idx=0, go to RUN.
- RUN: in_ready=0. Each cycle, add chunk idx ([idx*CHUNK +: CHUNK]) of A and B plus carry, write it into the working sum register, update carry, idx++.
  - On the last chunk (idx=NCHUNK−1), record the carry into the MSB and the final carry, then go to DONE.
- DONE: out_valid=1; sum/cout/ovf are loaded on entry to DONE and held stable. in_ready=0, so in_valid is ignored.
  - When out_ready=1 at a clock edge, return to IDLE.
- Latency: out_valid rises NCHUNK clock edges after the accepting edge. Best-case throughput is one operation per NCHUNK+2 cycles.
- sum/cout/ovf keep the last result after the handshake, until the next operation completes. They never show partial values during RUN.
- Arithmetic: modulo 2^WIDTH. cout and ovf are computed from the true full-width ripple, identical to a single-cycle WIDTH-bit adder.
- Simultaneous out_ready and in_valid in DONE: the result retires. New operands are accepted no earlier than the next cycle, in IDLE.
- Operand changes on a/b/cin/sub after acceptance have no effect.
- CHUNK=WIDTH: RUN lasts exactly 1 cycle.

Test Plan:
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; out_valid rises exactly 4 edges after acceptance.
- a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x0FED, cin=1 -> sum=0x2222, cout=0, ovf=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid and operands -> out_valid, sum, cout and ovf stay stable, in_ready stays 0. Raising out_ready for one cycle -> IDLE, and in_ready=1 on the next cycle.
- Reset mid-RUN (assert rst asynchronously 2 cycles after acceptance) -> out_valid=0, sum=0, in_ready=1 immediately; no stale result appears after reset release.
- WIDTH=3, CHUNK=3: a=7, b=7, cin=1 -> sum=7, cout=1, out_valid 1 edge after acceptance. WIDTH=8, CHUNK=1: 0xAA+0x55+1 -> sum=0x00, cout=1, latency 8.
